config_sequencer: RTL
=====================

# config_sequencer

Streams a configuration bitstream into the CGRA fabric's shared config bus (`config_addr`/`config_data`) that every PE tile decodes against its `tile_id` and unit code (SB=7, CB0=6, CB1=5, CLB=4). The block sits between the off-array loader (host interface or boot ROM) and the top-level config bus. It parses a framed word stream, issues each write as a single-cycle strobe with an idle gap, tracks progress, and validates the frame with a checksum.

## Interface
Parameters:
- `WRITE_GAP`, default 1: idle bus cycles inserted after each write strobe; 0 means no gap.
- `MAGIC`, default 16'hC0F1: required value of header bits [31:16].

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `reset`  in  1  Reset is asynchronous and active-high.
- `start`  in  1  Arms a new load; sampled only in IDLE, DONE or ERR.
- `in_data`  in  32  Bitstream word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  Block accepts a word this cycle.
- `config_addr`  out  32  Fabric config address: [31:16] unit code, [15:0] tile id.
- `config_data`  out  32  Fabric config data.
- `busy`  out  1  A load is in progress.
- `done`  out  1  Last load completed with a good checksum. Sticky.
- `error`  out  1  Last load failed. Sticky.
- `entries_written`  out  16  Number of write strobes issued in the current or last load.

## Operation
- Frame format, in order:
  - Header: [31:16] = `MAGIC`, [15:0] = N, the entry count.
  - N pairs of (addr word, data word).
  - Check word: the XOR of the header and all 2N entry words.
- States: IDLE, HDR, ADDR, DATA, WRITE, GAP, CHECK, DONE, ERR.
- IDLE/DONE/ERR + `start` → HDR. On this transition, clear `done`, `error`, `entries_written` and the checksum accumulator.
- HDR accept:
  - Magic mismatch → ERR.
  - N = 0 → CHECK.
  - Otherwise latch N → ADDR.
- ADDR accept:
  - addr[31:16] == 0 → ERR. Unit code 0 is reserved as the bus idle code.
  - Otherwise latch addr → DATA.
- DATA accept → WRITE.
- WRITE: lasts 1 cycle and increments `entries_written`. Then:
  - → GAP if `WRITE_GAP` > 0.
  - Else → ADDR if entries remain.
  - Else → CHECK.
- GAP: lasts `WRITE_GAP` cycles, then → ADDR or CHECK by the same rule as WRITE.
- CHECK accept:
  - Word equals the accumulator → DONE (`done`=1).
  - Otherwise → ERR (`error`=1).
- Every accepted word except the check word is XORed into the accumulator, including words in a frame later aborted by ERR.
- No rollback: writes already strobed before an ERR remain applied in the fabric.
- `start` is ignored in HDR, ADDR, DATA, WRITE, GAP and CHECK.
- `in_valid` with `in_ready` low is ignored. No word is consumed.

## Timing
- Reset values:
  - `config_addr` = 0, `config_data` = 0.
  - `in_ready` = 0, `busy` = 0, `done` = 0, `error` = 0, `entries_written` = 0.
  - State = IDLE.
- `in_ready` is a decode of state: high only in HDR, ADDR, DATA and CHECK. A word transfers on a rising edge where `in_valid` & `in_ready` are both high.
- `start` sampled at edge t → HDR from t; `in_ready` is high in cycle t+1.
- Write strobe:
  - The DATA word accepted at edge t drives registered `config_addr`/`config_data` = (latched addr, data word) during cycle t+1 only (WRITE state).
  - At edge t+1 both outputs return to 0. Unit code 0 matches no tile, so no enable fires.
- `entries_written` shows its incremented value from edge t+1.
- Minimum cycles per entry at full input rate is 3 + `WRITE_GAP`.
- `busy` = 1 in all states except IDLE, DONE and ERR. `done`/`error` assert on the edge that enters DONE/ERR.
- `entries_written` wraps at 16 bits. N ≤ 65535, so it cannot wrap within one frame.
- Asynchronous reset mid-load:
  - Outputs return to reset values immediately.
  - A strobe cut short is not re-issued.

## Test plan
- **Good frame, `WRITE_GAP`=1.** Stream header 0xC0F1_0002, (0x0007_0003, 0x5), (0x0004_0003, 0x2), then the correct XOR. Required: exactly two 1-cycle strobes, spaced 4 cycles apart. `config_addr` = 0 between strobes. Then `done`=1, `entries_written`=2, `busy`=0.
- **Bad magic.** Header 0xBEEF_0001. Required: ERR on the next edge, `error`=1, no strobe, `in_ready`=0 afterwards.
- **Checksum mismatch.** One-entry frame with check word flipped in bit 0. Required: one strobe is issued, then `error`=1 and `done`=0.
- **Backpressure and gaps.** Toggle `in_valid` randomly with `WRITE_GAP`=0 and N=3. Required: no word is consumed while `in_ready`=0, strobes stay 1 cycle wide, and `done`=1.
- **Reserved unit code and control edge cases.** Addr 0x0000_0005 in the entry → ERR. Then `start` from ERR → `error` clears and a good frame completes. Assert `start` during DATA → ignored.
- **Reset mid-strobe.** Assert `reset` during the WRITE cycle. Required: `config_addr`, `config_data` and `busy` are 0 immediately; the next `start` + good frame succeeds.

Source files
------------

// File: rtl/config_sequencer.sv
// config_sequencer
//   Parses a framed configuration word stream and writes it to the fabric's
//   shared config bus. The frame is a header (MAGIC, N), then N (addr, data)
//   pairs, then a check word equal to the XOR of every earlier word in the
//   frame. Each write is a one-cycle strobe. WRITE_GAP idle bus cycles follow
//   each strobe.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             arms a new load (only seen in IDLE/DONE/ERR)
//   in_data/in_valid  incoming bitstream word; in_ready accepts it
//   config_addr/data  registered fabric bus, zero whenever not strobing
//   busy              a load is in progress
//   done/error        sticky result of the last load
//   entries_written   strobes issued in the current or last load
module config_sequencer #(
    parameter int          WRITE_GAP = 1,
    parameter logic [15:0] MAGIC     = 16'hC0F1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] entries_written
);

    typedef enum logic [3:0] {
        IDLE, HDR, ADDR, DATA, WRITE, GAP, CHECK, DONE, ERR
    } state_t;

    // Last value of the gap counter before leaving GAP. It is unused when
    // WRITE_GAP is 0 because GAP is then never entered.
    localparam logic [15:0] GAP_LAST = (WRITE_GAP > 0) ? 16'(WRITE_GAP - 1) : 16'd0;

    state_t      state_reg, state_next;
    logic [15:0] remaining_reg;
    logic [31:0] addr_reg;
    logic [31:0] acc_reg;
    logic [15:0] gap_cnt_reg;
    logic [31:0] config_addr_reg, config_data_reg;
    logic [15:0] entries_reg;
    logic        done_reg, error_reg;

    logic accept;
    logic arm;

    assign in_ready = (state_reg == HDR) || (state_reg == ADDR) ||
                      (state_reg == DATA) || (state_reg == CHECK);
    assign busy     = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    assign accept   = in_valid && in_ready;
    assign arm      = start && !busy;

    assign config_addr     = config_addr_reg;
    assign config_data     = config_data_reg;
    assign done            = done_reg;
    assign error           = error_reg;
    assign entries_written = entries_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (in_data[31:16] != MAGIC)  state_next = ERR;
                    else if (in_data[15:0] == 0)  state_next = CHECK;
                    else                          state_next = ADDR;
                end
            end
            ADDR: begin
                // Unit code 0 is the bus idle code and can never be a target.
                if (accept) state_next = (in_data[31:16] == 16'd0) ? ERR : DATA;
            end
            DATA: begin
                if (accept) state_next = WRITE;
            end
            WRITE: begin
                // remaining_reg still counts the entry being written here.
                if (WRITE_GAP > 0)            state_next = GAP;
                else if (remaining_reg == 1)  state_next = CHECK;
                else                          state_next = ADDR;
            end
            GAP: begin
                // remaining_reg was already decremented on leaving WRITE.
                if (gap_cnt_reg == GAP_LAST)
                    state_next = (remaining_reg == 16'd0) ? CHECK : ADDR;
            end
            CHECK: begin
                if (accept) state_next = (in_data == acc_reg) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_reg   <= '0;
            addr_reg        <= '0;
            acc_reg         <= '0;
            gap_cnt_reg     <= '0;
            config_addr_reg <= '0;
            config_data_reg <= '0;
            entries_reg     <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            // The bus idles at zero; only the DATA accept loads a strobe,
            // so every strobe is exactly the one WRITE cycle wide.
            config_addr_reg <= '0;
            config_data_reg <= '0;

            if (arm) begin
                done_reg    <= 1'b0;
                error_reg   <= 1'b0;
                entries_reg <= '0;
                acc_reg     <= '0;
            end

            // The check word itself is never folded into the accumulator.
            if (accept && state_reg != CHECK) acc_reg <= acc_reg ^ in_data;

            if (accept && state_reg == HDR)  remaining_reg <= in_data[15:0];
            if (accept && state_reg == ADDR) addr_reg <= in_data;
            if (accept && state_reg == DATA) begin
                config_addr_reg <= addr_reg;
                config_data_reg <= in_data;
            end

            if (state_reg == WRITE) begin
                entries_reg   <= entries_reg + 16'd1;
                remaining_reg <= remaining_reg - 16'd1;
                gap_cnt_reg   <= '0;
            end
            if (state_reg == GAP) gap_cnt_reg <= gap_cnt_reg + 16'd1;

            if (state_next == DONE && state_reg != DONE) done_reg  <= 1'b1;
            if (state_next == ERR  && state_reg != ERR)  error_reg <= 1'b1;
        end
    end

endmodule
